// File: rtl/alu_op_issue_if.sv
// Command/result bus between a command producer, the issue stage and the
// downstream select stage. The producer side (master) drives commands and
// out_ready; the issue stage (slave) drives in_ready and all results.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A valid source holds its payload stable until that edge. in_ready
// depends only on the FIFO fill level, never on in_valid or out_ready.
interface alu_op_issue_if #(
   parameter int WIDTH = 4,
   parameter int AW    = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             f2;
   logic             f1;
   logic             f0;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_zero;
   logic [AW:0]      count;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, f2, f1, f0, opa, opb, out_valid,
             out_result, out_carry, out_zero, count
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, f2, f1, f0, opa, opb, out_valid,
             out_result, out_carry, out_zero, count
   );
endinterface

// File: rtl/alu_op_issue.sv
// Issue stage for the ALU function-select mux: buffers commands in a FIFO,
// issues them in arrival order as registered f2/f1/f0 selects and operands,
// and registers the matching result/flags alongside them. The issue register
// holds until the consumer accepts; a new command loads on the same edge.
module alu_op_issue #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic          clk,
   input logic          rst,
   alu_op_issue_if.slave bus
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [2:0]       r_mem_op [DEPTH];
   logic [WIDTH-1:0] r_mem_a  [DEPTH];
   logic [WIDTH-1:0] r_mem_b  [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic             r_out_valid;
   logic             r_f2;
   logic             r_f1;
   logic             r_f0;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;

   logic             w_in_ready;
   logic             w_push;
   logic             w_load;
   logic [2:0]       w_head_op;
   logic [WIDTH-1:0] w_head_a;
   logic [WIDTH-1:0] w_head_b;
   logic [WIDTH:0]   w_wide;
   logic [WIDTH-1:0] w_result;
   logic             w_carry;
   logic             w_zero;

   // Full blocks pushes even when a pop happens on the same edge.
   assign w_in_ready = (r_count != FULL_COUNT);
   assign w_push     = bus.in_valid & w_in_ready;
   // Refill the issue register whenever it is empty or being accepted.
   assign w_load     = (r_count != '0) & (~r_out_valid | bus.out_ready);

   assign w_head_op  = r_mem_op[r_rd_ptr];
   assign w_head_a   = r_mem_a[r_rd_ptr];
   assign w_head_b   = r_mem_b[r_rd_ptr];

   // Function of the FIFO head; bit WIDTH of w_wide is the carry/borrow/shift-out.
   always_comb begin
      w_wide = '0;
      case (w_head_op)
         3'b000:  w_wide = {1'b0, w_head_a} + {1'b0, w_head_b};
         3'b001:  w_wide = {1'b0, w_head_a} - {1'b0, w_head_b};
         3'b010:  w_wide = {1'b0, w_head_a & w_head_b};
         3'b011:  w_wide = {1'b0, w_head_a | w_head_b};
         3'b100:  w_wide = {1'b0, w_head_a ^ w_head_b};
         3'b101:  w_wide = {1'b0, ~w_head_a};
         3'b110:  w_wide = {w_head_a, 1'b0};
         default: w_wide = {1'b0, w_head_b};
      endcase
   end

   assign w_result = w_wide[WIDTH-1:0];
   assign w_carry  = w_wide[WIDTH];
   assign w_zero   = (w_result == '0);

   // FIFO storage; entries need no reset because the pointers discard them.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_op[r_wr_ptr] <= bus.in_op;
         r_mem_a[r_wr_ptr]  <= bus.in_a;
         r_mem_b[r_wr_ptr]  <= bus.in_b;
      end
   end

   // FIFO pointers and fill level; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_load})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue register: load from the head, or retire when accepted with nothing queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_f2        <= 1'b0;
         r_f1        <= 1'b0;
         r_f0        <= 1'b0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_f2        <= w_head_op[2];
         r_f1        <= w_head_op[1];
         r_f0        <= w_head_op[0];
         r_opa       <= w_head_a;
         r_opb       <= w_head_b;
         r_result    <= w_result;
         r_carry     <= w_carry;
         r_zero      <= w_zero;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.count      = r_count;
   assign bus.out_valid  = r_out_valid;
   assign bus.f2         = r_f2;
   assign bus.f1         = r_f1;
   assign bus.f0         = r_f0;
   assign bus.opa        = r_opa;
   assign bus.opb        = r_opb;
   assign bus.out_result = r_result;
   assign bus.out_carry  = r_carry;
   assign bus.out_zero   = r_zero;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: a table of hand-computed vectors streamed through
// the issue stage, plus directed sequences for latency, backpressure/full,
// push+pop with pointer wrap, and reset in the middle of traffic.
module tb_alu_op_issue;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] res;
      logic       carry;
      logic       zero;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   int   n_accepted;
   int   base;
   logic [16:0] exp_q[$];
   vec_t vecs[14];

   alu_op_issue_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   alu_op_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference function: {op, a, b, result, carry, zero}
   function automatic logic [16:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
      logic [4:0] s;
      logic [3:0] r;
      logic       c;
      r = 4'd0;
      c = 1'b0;
      case (op)
         3'd0: begin s = 5'(a) + 5'(b); r = s[3:0]; c = s[4]; end
         3'd1: begin r = a - b; c = (a < b); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
         default: r = b;
      endcase
      return {op, a, b, r, c, (r == 4'd0)};
   endfunction

   // Driver: present a command (pushed at the next edge) and record it as expected.
   task automatic drive_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [16:0] exp, input bit expect_push);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      if (expect_push) exp_q.push_back(exp);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   // Scoreboard: every accepted result must match the oldest expected command.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_accepted++;
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            check($sformatf("result_%0d", n_accepted),
                  32'({bus.f2, bus.f1, bus.f0, bus.opa, bus.opb,
                       bus.out_result, bus.out_carry, bus.out_zero}),
                  32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      n_accepted = 0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 3'd0;
      bus.in_a      = 4'd0;
      bus.in_b      = 4'd0;
      bus.out_ready = 1'b0;

      vecs[0]  = '{3'd0, 4'h5, 4'h3, 4'h8, 1'b0, 1'b0};
      vecs[1]  = '{3'd1, 4'h5, 4'h3, 4'h2, 1'b0, 1'b0};
      vecs[2]  = '{3'd2, 4'h5, 4'h3, 4'h1, 1'b0, 1'b0};
      vecs[3]  = '{3'd3, 4'h5, 4'h3, 4'h7, 1'b0, 1'b0};
      vecs[4]  = '{3'd4, 4'h5, 4'h3, 4'h6, 1'b0, 1'b0};
      vecs[5]  = '{3'd5, 4'h5, 4'h3, 4'hA, 1'b0, 1'b0};
      vecs[6]  = '{3'd6, 4'h5, 4'h3, 4'hA, 1'b0, 1'b0};
      vecs[7]  = '{3'd7, 4'h5, 4'h3, 4'h3, 1'b0, 1'b0};
      vecs[8]  = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0};
      vecs[9]  = '{3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1};
      vecs[10] = '{3'd6, 4'h8, 4'h7, 4'h0, 1'b1, 1'b1};
      vecs[11] = '{3'd1, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1};
      vecs[12] = '{3'd2, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
      vecs[13] = '{3'd5, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1};

      // Reset release
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_fsel", 32'({bus.f2, bus.f1, bus.f0}), 32'd0);
      check("rst_result", 32'(bus.out_result), 32'd0);
      check("rst_flags", 32'({bus.out_carry, bus.out_zero}), 32'd0);
      check("rst_operands", 32'({bus.opa, bus.opb}), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Single ADD: 9+8 -> 1 with carry, two-cycle latency
      bus.out_ready = 1'b1;
      drive_cmd(3'd0, 4'd9, 4'd8, {3'd0, 4'd9, 4'd8, 4'd1, 1'b1, 1'b0}, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check("add_lat_cycle1", 32'(bus.out_valid), 32'd0);
      tick();
      check("add_lat_cycle2", 32'(bus.out_valid), 32'd1);
      tick();
      check("add_valid_fall", 32'(bus.out_valid), 32'd0);
      check("add_data_held", 32'({bus.out_result, bus.out_carry}), 32'({4'd1, 1'b1}));

      // Table vectors streamed back-to-back, one result per cycle
      base = n_accepted;
      for (int i = 0; i < 14; i++) begin
         drive_cmd(vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].carry, vecs[i].zero},
                   1'b1);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      tick();
      check("stream_throughput", 32'(n_accepted - base), 32'd14);
      check("stream_idle", 32'(bus.out_valid), 32'd0);

      // Backpressure: fill to DEPTH behind one issued command
      bus.out_ready = 1'b0;
      base = n_accepted;
      for (int i = 0; i < 5; i++) begin
         drive_cmd(3'(i + 1), 4'(i + 2), 4'd3, alu_model(3'(i + 1), 4'(i + 2), 4'd3), 1'b1);
         tick();
      end
      check("full_count", 32'(bus.count), 32'd4);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_out_valid", 32'(bus.out_valid), 32'd1);
      drive_cmd(3'd7, 4'hE, 4'hE, 17'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_count", 32'(bus.count), 32'd4);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_outputs",
               32'({bus.out_valid, bus.f2, bus.f1, bus.f0, bus.opa, bus.opb, bus.out_result}),
               32'({1'b1, 3'd1, 4'd2, 4'd3, 4'hF}));
      end
      // Pop while full: the held-off command must still be refused on this edge
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("full_pop_no_push", 32'(bus.count), 32'd3);
      drain(20);
      check("drain_count", 32'(n_accepted - base), 32'd5);
      check("drain_empty", 32'({bus.out_valid, bus.count}), 32'd0);

      // Simultaneous push/pop at count 2, across several pointer wraps
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_cmd(3'(k), 4'(k), 4'(15 - k), alu_model(3'(k), 4'(k), 4'(15 - k)), 1'b1);
         tick();
      end
      check("pp_start_count", 32'(bus.count), 32'd2);
      bus.out_ready = 1'b1;
      for (int k = 3; k < 13; k++) begin
         drive_cmd(3'(k), 4'(k), 4'(15 - k), alu_model(3'(k), 4'(k), 4'(15 - k)), 1'b1);
         tick();
         check("pp_count", 32'(bus.count), 32'd2);
      end
      bus.in_valid = 1'b0;
      drain(20);
      check("pp_idle", 32'(bus.out_valid), 32'd0);

      // Reset mid-operation drops queued and issued commands
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_cmd(3'd0, 4'(k), 4'd1, 17'd0, 1'b0);
         tick();
      end
      bus.in_valid = 1'b0;
      check("pre_rst_count", 32'(bus.count), 32'd3);
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_count", 32'(bus.count), 32'd0);
      check("mid_rst_out", 32'({bus.out_valid, bus.f2, bus.f1, bus.f0, bus.out_result}), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      drive_cmd(3'd7, 4'd5, 4'd0, {3'd7, 4'd5, 4'd0, 4'd0, 1'b0, 1'b1}, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      drain(10);
      check("post_rst_idle", 32'({bus.out_valid, bus.count}), 32'd0);

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
